// File: rtl/des_round_sequencer.sv
// Control FSM for the iterative DES core: load, ROUNDS Feistel steps with the key-rotate
// schedule, final permutation, then hold the result until the consumer takes it.
`timescale 1ns/1ps
module des_round_sequencer #(
  parameter int ROUNDS = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic       in_decrypt,
  output logic       in_ready,
  input  logic       abort,
  output logic       dp_load,
  output logic       dp_round_en,
  output logic [3:0] dp_round,
  output logic [1:0] key_shift,
  output logic       key_rot_right,
  output logic       dp_final,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       decrypt_reg, decrypt_next;
  logic [1:0] shift_lut [16];

  // Encrypt left-rotate schedule: single-bit steps in rounds 1, 2, 9 and 16.
  for (genvar gi = 0; gi < 16; gi++) begin : g_shift_lut
    assign shift_lut[gi] = (gi == 0 || gi == 1 || gi == 8 || gi == 15) ? 2'd1 : 2'd2;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      decrypt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      decrypt_reg <= decrypt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    decrypt_next  = decrypt_reg;
    in_ready      = 1'b0;
    busy          = 1'b1;
    dp_load       = 1'b0;
    dp_round_en   = 1'b0;
    dp_round      = '0;
    key_shift     = '0;
    key_rot_right = 1'b0;
    dp_final      = 1'b0;
    out_valid     = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next   = LOAD;
          decrypt_next = in_decrypt;
        end
      end
      LOAD: begin
        dp_load    = 1'b1;
        cnt_next   = '0;
        state_next = ROUND;
      end
      ROUND: begin
        dp_round_en   = 1'b1;
        dp_round      = cnt_reg;
        key_rot_right = decrypt_reg;
        // Decrypt walks the schedule backwards from the fully rotated PC1 key, so round 0 needs no shift.
        if (decrypt_reg)
          key_shift = (cnt_reg == 4'd0) ? 2'd0 : shift_lut[4'd0 - cnt_reg];
        else
          key_shift = shift_lut[cnt_reg];
        if (cnt_reg == LAST_ROUND)
          state_next = FINAL;
        else
          cnt_next = cnt_reg + 4'd1;
      end
      FINAL: begin
        dp_final   = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // abort outranks every transition but is ignored in IDLE, so a same-cycle accept still lands.
    if (abort && state_reg != IDLE) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

endmodule
